// File: rtl/alu_issue_pkg.sv
// Shared types and default sizes for the ALU issue/writeback controller.
package alu_issue_pkg;

  localparam int ALU_DW   = 4;
  localparam int ALU_NREG = 4;
  localparam int ALU_AW   = 2;

  typedef logic [2:0] alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// NREG x DW register file: two asynchronous read ports and one write path
// in which an ALU writeback overrides a direct load to the same entry.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int DW   = ALU_DW,
  parameter int NREG = ALU_NREG,
  parameter int AW   = ALU_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  logic [DW-1:0] regs_reg  [NREG];
  logic [DW-1:0] regs_next [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_entry
      logic wb_hit;
      logic ld_hit;
      assign wb_hit = wb_en && (wb_addr == AW'(gi));
      assign ld_hit = ld_en && (ld_addr == AW'(gi));
      // Writeback checked first so it wins over a same-cycle load.
      assign regs_next[gi] = wb_hit ? wb_data : (ld_hit ? ld_data : regs_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= regs_next[i];
    end
  end

  assign rd1 = regs_reg[ra1];
  assign rd2 = regs_reg[ra2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the combinational ALU.
// Optional ALU_ISSUE_CNT_EN adds an 8-bit wrapping handshake counter (issue_cnt).
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DW   = ALU_DW,
  parameter int NREG = ALU_NREG,
  parameter int AW   = ALU_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_cout,
  output logic [AW-1:0] out_rd
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [7:0]    issue_cnt
`endif
);

  issue_state_t  state_reg;
  logic [AW-1:0] rd_reg;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  alu_op_t       op_reg;
  logic [DW-1:0] data_reg;
  logic          cout_reg;
  logic [AW-1:0] out_rd_reg;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic          wb_en;

  assign wb_en = (state_reg == EXEC);

  alu_issue_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra1     (in_rs1),
    .ra2     (in_rs2),
    .rd1     (rf_rd1),
    .rd2     (rf_rd2),
    .wb_en   (wb_en),
    .wb_addr (rd_reg),
    .wb_data (alu_result),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  // Operands latch only on accept, so ALU inputs are stable through EXEC
  // and keep their last values afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rd_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      data_reg   <= '0;
      cout_reg   <= 1'b0;
      out_rd_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= rf_rd1;
            b_reg     <= rf_rd2;
            op_reg    <= in_op;
            rd_reg    <= in_rd;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          data_reg   <= alu_result;
          cout_reg   <= alu_cout;
          out_rd_reg <= rd_reg;
          state_reg  <= DONE;
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 8'd0;
    end else if (state_reg == DONE && out_ready) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign issue_cnt = cnt_reg;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_op    = op_reg;
  assign out_data  = data_reg;
  assign out_cout  = cout_reg;
  assign out_rd    = out_rd_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with an XOR ALU stub and a
// transaction-level register-file model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rs1, in_rs2, in_rd;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_cout;
  logic [1:0] out_rd;
`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] issue_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] model_rf [4];
  bit         cur_le;
  logic [1:0] cur_la;
  logic [3:0] cur_ld;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cout   (out_cout),
    .out_rd     (out_rd)
`ifdef ALU_ISSUE_CNT_EN
    ,
    .issue_cnt  (issue_cnt)
`endif
  );

  // ALU stub
  assign alu_result = alu_a ^ alu_b;
  assign alu_cout   = alu_a[3] & alu_b[3];

  always #5 clk = ~clk;

  task automatic drive_ld(input bit en, input logic [1:0] a, input logic [3:0] d);
    ld_en = en; ld_addr = a; ld_data = d;
    cur_le = en; cur_la = a; cur_ld = d;
  endtask

  task automatic drive_rand_ld(input bit r);
    if (r) drive_ld(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    else   drive_ld(1'b0, 2'd0, 4'd0);
  endtask

  task automatic apply_ld();
    if (cur_le) model_rf[cur_la] = cur_ld;
  endtask

  task automatic do_load(input logic [1:0] a, input logic [3:0] d);
    drive_ld(1'b1, a, d);
    @(negedge clk);
    apply_ld();
    drive_ld(1'b0, 2'd0, 4'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_rf[i] = 4'd0;
  endtask

  // One instruction from offer to handshake; hold = cycles spent in DONE with out_ready low.
  task automatic issue_and_check(input string tag, input logic [2:0] op, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic [1:0] rd, input int hold,
                                 input bit rand_ld, input bit ld_acc_rs1, input bit ld_ex_rd);
    logic [3:0] ea, eb, er;
    logic       ec;
    ea = model_rf[rs1]; eb = model_rf[rs2];
    er = ea ^ eb;       ec = ea[3] & eb[3];

    n_total++; if (in_ready !== 1'b1) $display("FAIL %s idle_in_ready: got %b want 1", tag, in_ready); else n_pass++;
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; out_ready = 1'b0;
    if (ld_acc_rs1) drive_ld(1'b1, rs1, ~ea); else drive_rand_ld(rand_ld);
    @(negedge clk);
    apply_ld();

    in_valid = $urandom_range(0, 1) != 0; in_op = 3'($urandom_range(0, 7));
    in_rs1 = 2'($urandom_range(0, 3)); in_rs2 = 2'($urandom_range(0, 3)); in_rd = 2'($urandom_range(0, 3));
    out_ready = $urandom_range(0, 1) != 0;
    n_total++; if (alu_a !== ea) $display("FAIL %s exec_alu_a: got %h want %h", tag, alu_a, ea); else n_pass++;
    n_total++; if (alu_b !== eb) $display("FAIL %s exec_alu_b: got %h want %h", tag, alu_b, eb); else n_pass++;
    n_total++; if (alu_op !== op) $display("FAIL %s exec_alu_op: got %h want %h", tag, alu_op, op); else n_pass++;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL %s exec_flags: got valid=%b ready=%b want 0/0", tag, out_valid, in_ready); else n_pass++;
    if (ld_ex_rd) drive_ld(1'b1, rd, ~er); else drive_rand_ld(rand_ld);
    @(negedge clk);
    apply_ld();
    model_rf[rd] = er;

    n_total++; if (out_valid !== 1'b1) $display("FAIL %s done_valid: got %b want 1", tag, out_valid); else n_pass++;
    n_total++; if (out_data !== er) $display("FAIL %s out_data: got %h want %h", tag, out_data, er); else n_pass++;
    n_total++; if (out_cout !== ec) $display("FAIL %s out_cout: got %b want %b", tag, out_cout, ec); else n_pass++;
    n_total++; if (out_rd !== rd) $display("FAIL %s out_rd: got %h want %h", tag, out_rd, rd); else n_pass++;
    n_total++; if (alu_a !== ea || alu_b !== eb) $display("FAIL %s alu_hold: got %h/%h want %h/%h", tag, alu_a, alu_b, ea, eb); else n_pass++;

    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; in_valid = 1'b1;
      in_rs1 = 2'($urandom_range(0, 3)); in_rs2 = 2'($urandom_range(0, 3)); in_rd = 2'($urandom_range(0, 3));
      drive_rand_ld(rand_ld);
      @(negedge clk);
      apply_ld();
      n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL %s stall_flags: got valid=%b ready=%b want 1/0", tag, out_valid, in_ready); else n_pass++;
      n_total++; if (out_data !== er || out_rd !== rd) $display("FAIL %s stall_data: got %h/%h want %h/%h", tag, out_data, out_rd, er, rd); else n_pass++;
    end

    in_valid = 1'b0; out_ready = 1'b1;
    drive_rand_ld(rand_ld);
    @(negedge clk);
    apply_ld();
    out_ready = 1'b0;
    drive_ld(1'b0, 2'd0, 4'd0);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s post_hs_flags: got valid=%b ready=%b want 0/1", tag, out_valid, in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (dut.u_rf.regs_reg[i] !== model_rf[i])
        $display("FAIL %s regfile[%0d]: got %h want %h", tag, i, dut.u_rf.regs_reg[i], model_rf[i]); else n_pass++;
    end
    $display("txn %s op=%0h rs1=%0d rs2=%0d rd=%0d result=%h cout=%b", tag, op, rs1, rs2, rd, er, ec);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    out_ready = 1'b0; drive_ld(1'b0, 2'd0, 4'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_flags: got ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    n_total++; if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 3'd0)
      $display("FAIL reset_alu: got %h/%h/%h want 0/0/0", alu_a, alu_b, alu_op); else n_pass++;
    n_total++; if (out_data !== 4'd0 || out_cout !== 1'b0 || out_rd !== 2'd0)
      $display("FAIL reset_out: got %h/%b/%h want 0/0/0", out_data, out_cout, out_rd); else n_pass++;
`ifdef ALU_ISSUE_CNT_EN
    n_total++; if (issue_cnt !== 8'd0) $display("FAIL reset_issue_cnt: got %0d want 0", issue_cnt); else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (dut.u_rf.regs_reg[i] !== 4'd0) $display("FAIL reset_rf[%0d]: got %h want 0", i, dut.u_rf.regs_reg[i]); else n_pass++;
    end
    $display("txn reset done");
  endtask

  task automatic test_basic_and_stall();
    do_load(2'd0, 4'b1011);
    do_load(2'd1, 4'b1000);
    issue_and_check("basic_stall", 3'b010, 2'd0, 2'd1, 2'd2, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_same_reg();
    do_load(2'd0, 4'b1011);
    issue_and_check("same_reg", 3'b101, 2'd0, 2'd0, 2'd0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wb_collision();
    do_load(2'd1, 4'b0110);
    do_load(2'd3, 4'b1100);
    issue_and_check("wb_over_ld", 3'b011, 2'd1, 2'd3, 2'd3, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_ld_at_accept();
    do_load(2'd2, 4'b0110);
    do_load(2'd3, 4'b0011);
    issue_and_check("ld_at_accept", 3'b110, 2'd2, 2'd3, 2'd0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      issue_and_check("random", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_exec();
    do_load(2'd1, 4'h5);
    do_load(2'd3, 4'h9);
    in_valid = 1'b1; in_op = 3'b001; in_rs1 = 2'd1; in_rs2 = 2'd3; in_rd = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_exec_flags: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    n_total++; if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 3'd0)
      $display("FAIL rst_exec_alu: got %h/%h/%h want 0/0/0", alu_a, alu_b, alu_op); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'd0)
      $display("FAIL rst_exec_after: got valid=%b ready=%b data=%h want 0/1/0", out_valid, in_ready, out_data); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (dut.u_rf.regs_reg[i] !== model_rf[i])
        $display("FAIL rst_exec_rf[%0d]: got %h want %h", i, dut.u_rf.regs_reg[i], model_rf[i]); else n_pass++;
    end
    $display("txn reset during EXEC");
  endtask

`ifdef ALU_ISSUE_CNT_EN
  task automatic test_back_to_back();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 257; k++)
      issue_and_check("b2b", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 0, 1'b1, 1'b0, 1'b0);
    n_total++; if (issue_cnt !== 8'd1) $display("FAIL issue_cnt_wrap: got %0d want 1", issue_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and_stall();
    test_same_reg();
    test_wb_collision();
    test_ld_at_accept();
    test_random();
    test_reset_exec();
`ifdef ALU_ISSUE_CNT_EN
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
